fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL use one clock, clk, and an asynchronous active-low reset, rst_n; no other clock or reset SHALL exist.
REQ-002 Parameter RESET_PC, default 64'h0, SHALL set the first fetch address after reset.
REQ-003 Parameter BUF_DEPTH, default 2, SHALL set the number of instruction-buffer entries; it SHALL be a power of two and at least 2.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 imem_req_valid  output  1  fetch request to instruction memory.
REQ-007 imem_req_addr  output  64  word-aligned fetch address.
REQ-008 imem_req_ready  input  1  memory accepts the request this cycle.
REQ-009 imem_rsp_valid  input  1  response valid; responses are in order, one per accepted request, with latency of 1 or more cycles.
REQ-010 imem_rsp_data  input  32  fetched instruction word.
REQ-011 inst_valid  output  1  buffered instruction available to decode.
REQ-012 inst  output  32  instruction word, fed to the immediate generator and decoder.
REQ-013 inst_pc  output  64  address of inst.
REQ-014 inst_ready  input  1  decode consumes inst this cycle.
REQ-015 br_taken  input  1  taken-branch redirect, one-cycle pulse.
REQ-016 br_pc  input  64  PC of the taken branch.
REQ-017 br_imm  input  64  sign-extended branch immediate from the immediate generator, in half-word units.
REQ-018 misalign  output  1  sticky flag for a misaligned redirect target.

Function
REQ-019 The redirect target SHALL be br_pc + (br_imm << 1), computed modulo 2^64.
REQ-020 A request SHALL transfer when imem_req_valid && imem_req_ready are both high; the issue PC SHALL then advance by 4, wrapping modulo 2^64.
REQ-021 imem_req_valid SHALL be asserted only in state RUN and only when outstanding + buffer_count < BUF_DEPTH, so that every response always has a buffer slot.
REQ-022 imem_req_addr SHALL stay stable while imem_req_valid is high and imem_req_ready is low.
REQ-023 Each non-discarded response SHALL be written to the buffer as {pc, data}, with pc taken from a pc tag queue kept in issue order.
REQ-024 The buffer SHALL be a FIFO; inst, inst_pc and inst_valid SHALL come from its head with no combinational path from imem_rsp_*.
REQ-025 A response arriving at an empty buffer SHALL make inst_valid high one cycle later.
REQ-026 When a push and a pop occur in the same cycle on a full buffer, both SHALL succeed and the count SHALL be unchanged.
REQ-027 The state machine SHALL have three states: RUN, FLUSH and HALT.
REQ-028 On br_taken in RUN with target[1:0]==0, the block SHALL, in that same cycle: flush the buffer and drop inst_valid the next cycle; load the issue PC with the target; deassert imem_req_valid; set discard_cnt to the number of outstanding requests plus any request accepted that cycle, minus any response arriving that cycle.
REQ-029 After a redirect the block SHALL go to FLUSH if discard_cnt > 0, otherwise it SHALL stay in RUN.
REQ-030 In FLUSH, each response SHALL be dropped and SHALL decrement discard_cnt; when discard_cnt reaches 0 the block SHALL return to RUN and issue from the target on the next cycle.
REQ-031 A br_taken received in FLUSH SHALL reload the target and SHALL keep the current discard_cnt, adjusted for a response arriving that cycle.
REQ-032 On br_taken with target[1:0]!=0, the block SHALL set misalign, flush the buffer, and go to HALT (via FLUSH while discard_cnt > 0).
REQ-033 In HALT, no requests SHALL issue and inst_valid SHALL be 0; the block SHALL leave HALT only through reset.
REQ-034 br_taken SHALL take priority over a buffer pop in the same cycle; the popped instruction SHALL count as consumed.

Reset
REQ-035 Asserting rst_n low SHALL asynchronously set: state=RUN, issue PC=RESET_PC, buffer empty, outstanding=0, discard_cnt=0, imem_req_valid=0, inst_valid=0, inst=32'h0, inst_pc=64'h0, misalign=0.
REQ-036 The first request SHALL be issued in the first cycle after rst_n deasserts, at address RESET_PC.
REQ-037 Reset during outstanding requests SHALL clear all tracking; the integration SHALL hold memory in reset as well.

Structure
REQ-038 A shared package SHALL hold the state enum (RUN/FLUSH/HALT), XLEN=64, ILEN=32 and the constant 64'd4.
REQ-039 The buffer SHALL be one sub-module, fetch_fifo, parameterised by width and depth, providing push/pop/flush, count, full and empty.

Verification
REQ-040 Reset with RESET_PC=64'h1000, ready held 1, 1-cycle latency -> requests at 1000, 1004, 1008; inst_pc follows the same sequence; inst equals the memory contents.
REQ-041 inst_ready=0 for 10 cycles -> at most 2 outstanding plus buffered; no response is lost; order is preserved after release.
REQ-042 br_taken with br_pc=64'h2000, br_imm=64'hFFFF_FFFF_FFFF_FFF8, 2 outstanding -> 2 responses discarded, next inst_pc=64'h1FF0.
REQ-043 br_imm=64'h1 (target 0x2002) -> misalign=1, HALT, no further requests until reset.
REQ-044 Issue PC=64'hFFFF_FFFF_FFFF_FFFC -> next request address 64'h0.
REQ-045 rst_n pulsed low mid-FLUSH with random memory latency -> all outputs at reset values; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: data widths, the
// sequential-fetch increment, the fetch state encoding and the branch
// target helper.
package fetch_unit_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    // Sequential fetch advances one 32-bit instruction word.
    localparam logic [XLEN-1:0] PC_INC = 64'd4;

    // Fetch state encoding, kept as plain constants for legacy tools.
    typedef logic [1:0] state_t;
    localparam state_t ST_RUN   = 2'd0;
    localparam state_t ST_FLUSH = 2'd1;
    localparam state_t ST_HALT  = 2'd2;

    // The branch immediate is in half-word units, so it is doubled before
    // being added to the branch PC. The sum wraps modulo 2^XLEN.
    function automatic logic [XLEN-1:0] redirect_target(
        input logic [XLEN-1:0] br_pc,
        input logic [XLEN-1:0] br_imm
    );
        return br_pc + (br_imm << 1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO used as the instruction buffer and the PC tag
// queue. Depth must be a power of two so the pointers wrap naturally.
// Flush empties the FIFO and wins over a push or pop in the same cycle.
// A push into a full FIFO succeeds when a pop happens in the same cycle.
module fetch_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

    // Storage write port.
    // NOTE: the storage array has no reset; pointers and count define what is valid, and readers gate the head with empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointer and occupancy tracking.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit. Issues word-aligned fetches to instruction memory
// while the in-flight plus buffered count leaves room for every response,
// tags each request with its PC, and buffers responses for decode.
// Taken branches redirect fetch; responses for the old path are counted
// and dropped while in FLUSH. A misaligned branch target sets a sticky
// flag and parks the unit in HALT until reset.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    output logic [63:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [63:0] inst_pc,
    input  logic        inst_ready,
    input  logic        br_taken,
    input  logic [63:0] br_pc,
    input  logic [63:0] br_imm,
    output logic        misalign
);

    // BUF_DEPTH is expected to be a power of two, at least 2.
    localparam int CW = $clog2(BUF_DEPTH) + 1;
    localparam int SW = CW + 1;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic            misalign_q, misalign_d;

    logic [XLEN-1:0] target;
    logic            target_ok;
    logic [CW-1:0]   redir_discard;

    logic [CW-1:0]   tag_count;
    logic [XLEN-1:0] tag_pc;
    logic            tag_full;
    logic            tag_empty;

    logic [CW-1:0]        buf_count;
    logic [XLEN+ILEN-1:0] buf_head;
    logic                 buf_full;
    logic                 buf_empty;

    logic credit_ok;
    logic req_fire;
    logic rsp_keep;
    logic buf_pop;
    logic buf_flush;

    assign target    = redirect_target(br_pc, br_imm);
    assign target_ok = (target[1:0] == 2'b00);

    // Requests are only issued while every possible response has a slot.
    assign credit_ok = ({1'b0, tag_count} + {1'b0, buf_count}) < SW'(BUF_DEPTH);

    // Held low during reset; dropped immediately on a redirect.
    assign imem_req_valid = rst_n && (state_q == ST_RUN) && !br_taken
                            && !tag_full && credit_ok;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Responses are kept only in RUN and never in a redirect cycle, where
    // they belong to the abandoned path.
    assign rsp_keep  = imem_rsp_valid && !tag_empty && (state_q == ST_RUN)
                       && !br_taken && (!buf_full || buf_pop);
    assign buf_pop   = inst_ready && !buf_empty;
    assign buf_flush = br_taken && (state_q != ST_HALT);

    // Requests outstanding after this cycle, counting the one that fires now
    // and excluding the one that returns now.
    assign redir_discard = tag_count + CW'(req_fire) - CW'(imem_rsp_valid);

    // PC tags of issued requests, in issue order; every response pops one.
    fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (BUF_DEPTH)
    ) u_tag_q (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (req_fire),
        .push_data_i (pc_q),
        .pop_i       (imem_rsp_valid),
        .flush_i     (1'b0),
        .head_o      (tag_pc),
        .count_o     (tag_count),
        .full_o      (tag_full),
        .empty_o     (tag_empty)
    );

    // Instruction buffer holding {pc, word} for decode.
    fetch_fifo #(
        .WIDTH (XLEN + ILEN),
        .DEPTH (BUF_DEPTH)
    ) u_inst_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (rsp_keep),
        .push_data_i ({tag_pc, imem_rsp_data}),
        .pop_i       (buf_pop),
        .flush_i     (buf_flush),
        .head_o      (buf_head),
        .count_o     (buf_count),
        .full_o      (buf_full),
        .empty_o     (buf_empty)
    );

    assign inst_valid = !buf_empty && (state_q != ST_HALT);
    assign inst       = inst_valid ? buf_head[ILEN-1:0] : '0;
    assign inst_pc    = inst_valid ? buf_head[XLEN+ILEN-1:ILEN] : '0;
    assign misalign   = misalign_q;

    // Next-state logic for the fetch state machine, issue PC and discard count.
    // NOTE: every output of this block gets a default first, so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        discard_d  = discard_q;
        misalign_d = misalign_q;

        if (req_fire) begin
            pc_d = pc_q + PC_INC;
        end

        case (state_q)
            ST_RUN: begin
                if (br_taken) begin
                    discard_d = redir_discard;
                    if (target_ok) begin
                        pc_d    = target;
                        state_d = (redir_discard != '0) ? ST_FLUSH : ST_RUN;
                    end else begin
                        misalign_d = 1'b1;
                        state_d    = (redir_discard != '0) ? ST_FLUSH : ST_HALT;
                    end
                end
            end
            ST_FLUSH: begin
                if (imem_rsp_valid) begin
                    discard_d = discard_q - CW'(1);
                end
                if (br_taken) begin
                    if (target_ok) begin
                        pc_d = target;
                    end else begin
                        misalign_d = 1'b1;
                    end
                end
                if (discard_d == '0) begin
                    state_d = misalign_d ? ST_HALT : ST_RUN;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State, issue PC, discard count and sticky misalign registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            discard_q  <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            discard_q  <= discard_d;
            misalign_q <= misalign_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order instruction memory model
// of configurable latency. Memory word at address A is A[31:0] ^ 32'hC0DE_0000.
module tb_fetch_unit;

    localparam logic [63:0] RST_PC = 64'h1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req_valid;
    logic [63:0] imem_req_addr;
    logic        imem_req_ready = 1'b1;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        inst_ready = 1'b1;
    logic        br_taken = 1'b0;
    logic [63:0] br_pc = '0;
    logic [63:0] br_imm = '0;
    logic        misalign;

    fetch_unit #(
        .RESET_PC  (RST_PC),
        .BUF_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .br_taken       (br_taken),
        .br_pc          (br_pc),
        .br_imm         (br_imm),
        .misalign       (misalign)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int lat      = 1;
    bit lat_rand = 1'b0;
    int last_due = 0;
    logic s_req_valid = 1'b0;

    logic [63:0] pend_addr [$];
    int          pend_due  [$];
    logic [63:0] req_log   [$];
    logic [63:0] cons_pc   [$];
    logic [31:0] cons_data [$];

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [63:0] req_at(input int i);
        return (i < req_log.size()) ? req_log[i] : 64'hBAD0_BAD0_BAD0_BAD0;
    endfunction

    function automatic logic [63:0] cpc_at(input int i);
        return (i < cons_pc.size()) ? cons_pc[i] : 64'hBAD0_BAD0_BAD0_BAD0;
    endfunction

    function automatic logic [63:0] cdat_at(input int i);
        return (i < cons_data.size()) ? 64'(cons_data[i]) : 64'hBAD0_BAD0_BAD0_BAD0;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive the memory response, log request and consume
    // handshakes, then advance to the next falling edge.
    task automatic step();
        int due;
        #1;
        if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        #1;
        s_req_valid = imem_req_valid;
        if (imem_req_valid && imem_req_ready) begin
            due = cyc + (lat_rand ? int'($urandom_range(1, 4)) : lat);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend_addr.push_back(imem_req_addr);
            pend_due.push_back(due);
            req_log.push_back(imem_req_addr);
        end
        if (inst_valid && inst_ready) begin
            cons_pc.push_back(inst_pc);
            cons_data.push_back(inst);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    // Assert reset (memory is held in reset too), check reset outputs,
    // release, and check the first request.
    task automatic apply_reset(input string tag);
        rst_n = 1'b0;
        #1;
        pend_addr.delete();
        pend_due.delete();
        last_due       = 0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        check({tag, "_rst_req_valid"}, 64'(imem_req_valid), 64'd0);
        check({tag, "_rst_inst_valid"}, 64'(inst_valid), 64'd0);
        check({tag, "_rst_inst"}, 64'(inst), 64'd0);
        check({tag, "_rst_inst_pc"}, inst_pc, 64'd0);
        check({tag, "_rst_misalign"}, 64'(misalign), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check({tag, "_first_req_valid"}, 64'(imem_req_valid), 64'd1);
        check({tag, "_first_req_addr"}, imem_req_addr, 64'h1000);
        req_log.delete();
        cons_pc.delete();
        cons_data.delete();
    endtask

    initial begin
        int c0;
        int r0;
        int max_inflight;
        int errs;

        rst_n = 1'b0;
        @(negedge clk);

        // Reset and sequential fetch, ready held high, latency 1.
        apply_reset("a");
        step();
        check("a_iv_before_rsp", 64'(inst_valid), 64'd0);
        step();
        check("a_iv_after_rsp", 64'(inst_valid), 64'd1);
        check("a_inst_pc_head", inst_pc, 64'h1000);
        check("a_inst_head", 64'(inst), 64'hC0DE_1000);
        repeat (10) step();
        check("a_req0", req_at(0), 64'h1000);
        check("a_req1", req_at(1), 64'h1004);
        check("a_req2", req_at(2), 64'h1008);
        check("a_pc0", cpc_at(0), 64'h1000);
        check("a_pc1", cpc_at(1), 64'h1004);
        check("a_pc2", cpc_at(2), 64'h1008);
        check("a_data1", cdat_at(1), 64'hC0DE_1004);
        check("a_data2", cdat_at(2), 64'hC0DE_1008);

        // Decode stall for 10 cycles, then release.
        c0 = cons_pc.size();
        inst_ready = 1'b0;
        max_inflight = 0;
        repeat (10) begin
            step();
            if (req_log.size() - cons_pc.size() > max_inflight)
                max_inflight = req_log.size() - cons_pc.size();
        end
        check("b_stall_no_consume", 64'(cons_pc.size()), 64'(c0));
        check("b_stall_inflight", 64'(max_inflight), 64'd2);
        inst_ready = 1'b1;
        repeat (20) step();
        errs = 0;
        for (int i = 0; i < cons_pc.size(); i++) begin
            if (cons_pc[i] !== 64'h1000 + 64'(4 * i)) errs++;
            if (cons_data[i] !== mem_word(64'h1000 + 64'(4 * i))) errs++;
        end
        check("b_order_errs", 64'(errs), 64'd0);
        check("b_progress", 64'(cons_pc.size() >= c0 + 8), 64'd1);
        check("b_nothing_lost", 64'(req_log.size() - cons_pc.size() <= 2), 64'd1);

        // Redirect with two requests outstanding, latency 3: target 0x1FF0.
        lat = 3;
        for (int i = 0; i < 20 && pend_addr.size() != 2; i++) step();
        check("c_pending_at_br", 64'(pend_addr.size()), 64'd2);
        br_taken = 1'b1;
        br_pc    = 64'h2000;
        br_imm   = 64'hFFFF_FFFF_FFFF_FFF8;
        step();
        br_taken = 1'b0;
        check("c_br_cycle_req_valid", 64'(s_req_valid), 64'd0);
        check("c_iv_after_br", 64'(inst_valid), 64'd0);
        c0 = cons_pc.size();
        r0 = req_log.size();
        for (int i = 0; i < 40 && cons_pc.size() <= c0; i++) step();
        check("c_first_req_after_br", req_at(r0), 64'h1FF0);
        check("c_inst_pc_after_br", cpc_at(c0), 64'h1FF0);
        check("c_inst_after_br", cdat_at(c0), 64'hC0DE_1FF0);

        // Issue PC wraps from 0xFFFF_FFFF_FFFF_FFFC to 0.
        lat = 1;
        br_taken = 1'b1;
        br_pc    = 64'hFFFF_FFFF_FFFF_FFF0;
        br_imm   = 64'd6;
        step();
        br_taken = 1'b0;
        c0 = cons_pc.size();
        r0 = req_log.size();
        for (int i = 0; i < 40 && cons_pc.size() < c0 + 2; i++) step();
        check("d_req_top", req_at(r0), 64'hFFFF_FFFF_FFFF_FFFC);
        check("d_req_wrap", req_at(r0 + 1), 64'h0);
        check("d_pc_top", cpc_at(c0), 64'hFFFF_FFFF_FFFF_FFFC);
        check("d_data_top", cdat_at(c0), 64'h3F21_FFFC);
        check("d_pc_wrap", cpc_at(c0 + 1), 64'h0);
        check("d_data_wrap", cdat_at(c0 + 1), 64'hC0DE_0000);

        // Misaligned target 0x2002: sticky flag, HALT, no more requests.
        br_taken = 1'b1;
        br_pc    = 64'h2000;
        br_imm   = 64'h1;
        step();
        br_taken = 1'b0;
        check("e_misalign_set", 64'(misalign), 64'd1);
        r0 = req_log.size();
        repeat (15) step();
        check("e_halt_no_requests", 64'(req_log.size()), 64'(r0));
        check("e_halt_req_valid", 64'(imem_req_valid), 64'd0);
        check("e_halt_inst_valid", 64'(inst_valid), 64'd0);
        check("e_misalign_sticky", 64'(misalign), 64'd1);

        // Leave HALT through reset, then reset again in the middle of FLUSH
        // with random memory latency.
        apply_reset("f1");
        lat_rand = 1'b1;
        for (int i = 0; i < 40 && pend_addr.size() != 2; i++) step();
        check("f_pending_at_br", 64'(pend_addr.size()), 64'd2);
        br_taken = 1'b1;
        br_pc    = 64'h3000;
        br_imm   = 64'h0;
        step();
        br_taken = 1'b0;
        check("f_flush_req_valid", 64'(imem_req_valid), 64'd0);
        apply_reset("f2");
        for (int i = 0; i < 80 && cons_pc.size() < 4; i++) step();
        check("f_pc0", cpc_at(0), 64'h1000);
        check("f_pc1", cpc_at(1), 64'h1004);
        check("f_pc2", cpc_at(2), 64'h1008);
        check("f_pc3", cpc_at(3), 64'h100C);
        check("f_data3", cdat_at(3), 64'hC0DE_100C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
